// File: rtl/vga_timing_pkg.sv
// Shared timing defaults (640x480@60 from a 50 MHz clock), the colour bundle type
// and a window-compare helper used by the VGA timing controller.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int DEF_H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Half-open window test: lo <= val < hi
    function automatic logic in_range(input logic [9:0] val, input int lo, input int hi);
        return (int'(val) >= lo) && (int'(val) < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-rate enable: tick is high for one CLK every CLK_DIV cycles; the first tick
// arrives CLK_DIV cycles after reset release. CLK_DIV=1 ticks every cycle.
module pixel_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic RST_N,
    output logic tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel/line counters, active window, sync pulses, a one-tick
// output register aligning colour with syncs, and a frame-synchronous switch snapshot.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [9:0]  SW,
    input  logic [7:0]  RED_IN,
    input  logic [7:0]  GRN_IN,
    input  logic [7:0]  BLU_IN,
    output logic [9:0]  hPixel,
    output logic [8:0]  vLine,
    output logic [9:0]  SW_LAT,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VID_EN,
    output logic        FRAME_START
);

    localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam logic SYNC_ON    = SYNC_POL;
    localparam logic SYNC_OFF   = ~SYNC_POL;

    logic tick;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .CLK   (CLK),
        .RST_N (RST_N),
        .tick  (tick)
    );

    logic [9:0] h_count_q, h_count_d;
    logic [9:0] v_count_q, v_count_d;
    logic       h_last, v_last, frame_wrap;
    logic       v_visible, active, hs0, vs0;

    rgb_t       rgb_q, rgb_d;
    logic       vid_en_q, vid_en_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       frame_start_q, frame_start_d;
    logic [9:0] sw_meta_q, sw_sync_q;
    logic [9:0] sw_lat_q, sw_lat_d;

    always_comb begin
        h_last     = (h_count_q == 10'(H_TOTAL - 1));
        v_last     = (v_count_q == 10'(V_TOTAL - 1));
        frame_wrap = tick && h_last && v_last;

        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (tick) begin
            if (h_last) begin
                h_count_d = '0;
                v_count_d = v_last ? '0 : v_count_q + 10'd1;
            end else begin
                h_count_d = h_count_q + 10'd1;
            end
        end
    end

    // Stage 0: everything the generator and the output register see, decoded straight from the counters
    always_comb begin
        v_visible = in_range(v_count_q, 0, V_VISIBLE);
        active    = v_visible && in_range(h_count_q, 0, H_VISIBLE);
        hs0       = in_range(h_count_q, H_SYNC_START, H_SYNC_END);
        vs0       = in_range(v_count_q, V_SYNC_START, V_SYNC_END);
        hPixel    = active ? h_count_q : '0;
        vLine     = v_visible ? v_count_q[8:0] : '0;
    end

    always_comb begin
        rgb_d         = rgb_q;
        vid_en_d      = vid_en_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        sw_lat_d      = sw_lat_q;
        frame_start_d = frame_wrap;
        if (tick) begin
            rgb_d    = active ? rgb_t'{r: RED_IN, g: GRN_IN, b: BLU_IN} : '0;
            vid_en_d = active;
            hs_d     = hs0 ? SYNC_ON : SYNC_OFF;
            vs_d     = vs0 ? SYNC_ON : SYNC_OFF;
        end
        if (frame_wrap) begin
            sw_lat_d = sw_sync_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            h_count_q     <= '0;
            v_count_q     <= '0;
            rgb_q         <= '0;
            vid_en_q      <= 1'b0;
            hs_q          <= SYNC_OFF;
            vs_q          <= SYNC_OFF;
            frame_start_q <= 1'b0;
            sw_meta_q     <= '0;
            sw_sync_q     <= '0;
            sw_lat_q      <= '0;
        end else begin
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            rgb_q         <= rgb_d;
            vid_en_q      <= vid_en_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
            sw_meta_q     <= SW;
            sw_sync_q     <= sw_meta_q;
            sw_lat_q      <= sw_lat_d;
        end
    end

    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;
    assign VID_EN      = vid_en_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign FRAME_START = frame_start_q;
    assign SW_LAT      = sw_lat_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl on a shrunken raster, checked every CLK against
// a model that derives the raster position from the number of ticks since reset.
module tb_vga_timing_ctrl;

    localparam int CLK_DIV   = 2;
    localparam int H_VISIBLE = 16;
    localparam int H_FP      = 2;
    localparam int H_SYNC    = 4;
    localparam int H_BP      = 3;
    localparam int V_VISIBLE = 10;
    localparam int V_FP      = 1;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 2;
    localparam int SYNC_POL  = 0;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int FRAME     = H_TOTAL * V_TOTAL;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [9:0] SW;
    logic [7:0] RED_IN, GRN_IN, BLU_IN;
    logic [9:0] hPixel;
    logic [8:0] vLine;
    logic [9:0] SW_LAT;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VID_EN, FRAME_START;

    always #5 CLK = ~CLK;

    vga_timing_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .SYNC_POL  (1'(SYNC_POL))
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .SW          (SW),
        .RED_IN      (RED_IN),
        .GRN_IN      (GRN_IN),
        .BLU_IN      (BLU_IN),
        .hPixel      (hPixel),
        .vLine       (vLine),
        .SW_LAT      (SW_LAT),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VID_EN      (VID_EN),
        .FRAME_START (FRAME_START)
    );

    int checks = 0;
    int passes = 0;

    // Model state: CLK edges since release, ticks since release, expected registered outputs
    int edges, ticks;
    int exp_r, exp_g, exp_b, exp_vid, exp_hs, exp_vs, exp_fs, exp_sw_lat;
    int sw_hist[$];
    int frame_pulses;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelEdge(input logic rst_n, input int sw, input int r, input int g, input int b);
        int p, h, v, sw_seen;
        bit act;
        if (!rst_n) begin
            edges = 0;  ticks = 0;
            exp_r = 0;  exp_g = 0;  exp_b = 0;  exp_vid = 0;
            exp_hs = 1 - SYNC_POL;  exp_vs = 1 - SYNC_POL;
            exp_fs = 0; exp_sw_lat = 0;
            sw_hist = '{0, 0};
        end else begin
            sw_seen = sw_hist[0];
            void'(sw_hist.pop_front());
            sw_hist.push_back(sw);
            edges++;
            exp_fs = 0;
            if (edges % CLK_DIV == 0) begin
                p   = ticks % FRAME;
                h   = p % H_TOTAL;
                v   = p / H_TOTAL;
                act = (h < H_VISIBLE) && (v < V_VISIBLE);
                exp_r   = act ? r : 0;
                exp_g   = act ? g : 0;
                exp_b   = act ? b : 0;
                exp_vid = act ? 1 : 0;
                exp_hs  = (h >= H_VISIBLE + H_FP && h < H_VISIBLE + H_FP + H_SYNC) ? SYNC_POL : 1 - SYNC_POL;
                exp_vs  = (v >= V_VISIBLE + V_FP && v < V_VISIBLE + V_FP + V_SYNC) ? SYNC_POL : 1 - SYNC_POL;
                if (p == FRAME - 1) begin
                    exp_fs     = 1;
                    exp_sw_lat = sw_seen;
                    frame_pulses++;
                end
                ticks++;
            end
        end
    endtask

    task automatic compareAll();
        int p, h, v;
        p = ticks % FRAME;
        h = p % H_TOTAL;
        v = p / H_TOTAL;
        checkOutput("hPixel", hPixel, (h < H_VISIBLE && v < V_VISIBLE) ? h : 0);
        checkOutput("vLine", vLine, (v < V_VISIBLE) ? v : 0);
        checkOutput("VGA_R", VGA_R, exp_r);
        checkOutput("VGA_G", VGA_G, exp_g);
        checkOutput("VGA_B", VGA_B, exp_b);
        checkOutput("VID_EN", VID_EN, exp_vid);
        checkOutput("VGA_HS", VGA_HS, exp_hs);
        checkOutput("VGA_VS", VGA_VS, exp_vs);
        checkOutput("FRAME_START", FRAME_START, exp_fs);
        checkOutput("SW_LAT", SW_LAT, exp_sw_lat);
    endtask

    // One CLK: drive at the falling edge, let the DUT and model see the rising edge, check 1 ns later
    task automatic applyStimulus(input logic rst_n);
        @(negedge CLK);
        RST_N  = rst_n;
        RED_IN = 8'($urandom);
        GRN_IN = 8'($urandom);
        BLU_IN = 8'($urandom);
        if ($urandom_range(0, 39) == 0) SW = 10'($urandom);
        @(posedge CLK);
        modelEdge(RST_N, SW, RED_IN, GRN_IN, BLU_IN);
        #1;
        compareAll();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int budget;
        frame_pulses = 0;
        RST_N  = 1'b0;
        SW     = 10'h001;
        RED_IN = '0;
        GRN_IN = '0;
        BLU_IN = '0;

        for (int i = 0; i < 4; i++) applyStimulus(1'b0);

        // Two full frames plus margin, with a forced switch change in mid-frame
        for (int i = 0; i < 2 * FRAME * CLK_DIV + 60; i++) begin
            if (i == FRAME * CLK_DIV / 2) SW = 10'h004;
            applyStimulus(1'b1);
        end

        // Run to an arbitrary mid-frame point, then hold reset for 3 CLK
        budget = 4 * FRAME * CLK_DIV;
        while (!((ticks % FRAME) == 4 * H_TOTAL + 7) && budget > 0) begin
            applyStimulus(1'b1);
            budget--;
        end
        checkOutput("midframe_reach", (budget > 0) ? 1 : 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0);

        for (int i = 0; i < 2 * FRAME * CLK_DIV + 40; i++) applyStimulus(1'b1);

        checkOutput("frame_pulse_count", frame_pulses, 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
